// File: rtl/mdio_peripheral.sv
// mdio_peripheral: MDIO (clause 22) management peripheral that oversamples MDC on the system clock,
// decodes read/write frames addressed to PHY_ADDR and drives read data back on MDIO_IN.
module mdio_peripheral #(
    parameter logic [4:0] PHY_ADDR = 5'd0,
    parameter bit         MDC_SYNC = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MDC,
    input  logic        MDIO_OUT,
    input  logic        MDIO_OE,
    output logic        MDIO_IN,
    output logic        MDIO_IN_OE,
    output logic [4:0]  ADDR,
    output logic [15:0] WR_DATA,
    output logic        WR_STB,
    input  logic [15:0] RD_DATA,
    output logic        MDIO_DONE
);
    typedef enum logic [3:0] {IDLE, START, OPCODE, PHYADR, REGADR, TURN, WDATA, RDATA, SKIP} state_t;
    state_t state, next;
    logic [2:0] q0, q1, s;
    logic mdc_prev, rise, fall, d, oe, rd, wr_fire;
    logic [4:0] cnt;
    logic [14:0] sr;
    logic [15:0] rd_sr;
    // MDC, MDIO_OUT and MDIO_OE share one synchronizer so data stays aligned with the sampled edge
    assign s = MDC_SYNC ? q1 : q0;
    assign rise = s[2] & ~mdc_prev;
    assign fall = ~s[2] & mdc_prev;
    assign d = s[1];
    assign oe = s[0];
    assign wr_fire = rise && oe && state == WDATA && cnt == 5'd31;
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            q0 <= '0;
            q1 <= '0;
            mdc_prev <= 1'b0;
            state <= IDLE;
        end else begin
            q0 <= {MDC, MDIO_OUT, MDIO_OE};
            q1 <= q0;
            mdc_prev <= s[2];
            state <= next;
        end
    end
    // cnt holds the index of the frame bit the next rise will sample
    always_comb begin
        next = state;
        if (rise) begin
            case (state)
                IDLE:    next = (oe && !d) ? START : IDLE;
                START:   next = !oe ? IDLE : d ? OPCODE : SKIP;
                OPCODE:  next = !oe ? IDLE : cnt != 5'd3 ? OPCODE : (sr[0] ^ d) ? PHYADR : SKIP;
                PHYADR:  next = !oe ? IDLE : cnt != 5'd8 ? PHYADR : ({sr[3:0], d} == PHY_ADDR) ? REGADR : SKIP;
                REGADR:  next = !oe ? IDLE : cnt == 5'd13 ? TURN : REGADR;
                TURN:    next = cnt == 5'd15 ? (rd ? RDATA : WDATA) : TURN;
                WDATA:   next = (!oe || cnt == 5'd31) ? IDLE : WDATA;
                default: next = cnt == 5'd31 ? IDLE : state;
            endcase
        end
    end
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
            sr <= '0;
            rd <= 1'b0;
            rd_sr <= '0;
            ADDR <= '0;
            WR_DATA <= '0;
            WR_STB <= 1'b0;
            MDIO_DONE <= 1'b0;
            MDIO_IN <= 1'b0;
            MDIO_IN_OE <= 1'b0;
        end else begin
            cnt <= (next == IDLE) ? 5'd0 : rise ? cnt + 5'd1 : cnt;
            sr <= rise ? {sr[13:0], d} : sr;
            rd <= (rise && state == OPCODE && cnt == 5'd3) ? sr[0] : rd;
            ADDR <= (state == REGADR && next == TURN) ? {sr[3:0], d} : ADDR;
            WR_STB <= wr_fire;
            WR_DATA <= wr_fire ? {sr, d} : WR_DATA;
            MDIO_DONE <= wr_fire || (rise && state == RDATA && cnt == 5'd31);
            rd_sr <= (rise && state == TURN && rd && cnt == 5'd15) ? RD_DATA :
                     (fall && state == RDATA) ? {rd_sr[14:0], 1'b0} : rd_sr;
            MDIO_IN <= (fall && state == RDATA) ? rd_sr[15] : (next == IDLE) ? 1'b0 : MDIO_IN;
            MDIO_IN_OE <= (fall && state == TURN && rd && cnt == 5'd15) ? 1'b1 :
                          (next == IDLE) ? 1'b0 : MDIO_IN_OE;
        end
    end
endmodule

// File: tb/tb_mdio_peripheral.sv
// tb_mdio_peripheral: drives MDIO frames as a controller would and checks them against
// a frame-level model of which frames are accepted and what they produce.
module tb_mdio_peripheral;
    localparam logic [4:0] P = 5'd0;
    localparam int H = 5;
    typedef struct {
        logic [1:0]  st, op;
        logic [4:0]  phy, regad;
        logic [15:0] data, rd;
        int          drop;
        logic [4:0]  e_addr;
        logic [15:0] e_wd;
        int          e_stb, e_done;
        logic [15:0] e_rdv;
        logic [31:0] e_oe;
    } vec_t;
    logic clk = 1'b0, rst = 1'b1, mdc = 1'b0, mo = 1'b0, moe = 1'b0;
    logic [15:0] rd_data = 16'h0;
    logic mi, mi_oe, wr_stb, done;
    logic [4:0] addr;
    logic [15:0] wr_data;
    int n_chk = 0, n_fail = 0, stb_n = 0, done_n = 0, pair_bad = 0;
    logic [4:0] cur_addr;
    logic [15:0] cur_wd;
    vec_t tbl[8];
    vec_t v;
    always #5 clk = ~clk;
    mdio_peripheral #(.PHY_ADDR(P), .MDC_SYNC(1'b1)) dut (
        .CLK(clk), .RESET(rst), .MDC(mdc), .MDIO_OUT(mo), .MDIO_OE(moe),
        .MDIO_IN(mi), .MDIO_IN_OE(mi_oe), .ADDR(addr), .WR_DATA(wr_data),
        .WR_STB(wr_stb), .RD_DATA(rd_data), .MDIO_DONE(done)
    );
    always @(negedge clk) begin
        if (wr_stb) stb_n++;
        if (done) done_n++;
        if (wr_stb && !done) pair_bad++;
    end
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic bit_cycle(input logic o, input logic e, output logic si, output logic so);
        @(negedge clk);
        mo = o;
        moe = e;
        repeat (H) @(negedge clk);
        mdc = 1'b1;
        si = mi;
        so = mi_oe;
        repeat (H) @(negedge clk);
        mdc = 1'b0;
    endtask
    function automatic vec_t mk(logic [1:0] st, logic [1:0] op, logic [4:0] phy, logic [4:0] regad,
                                logic [15:0] data, logic [15:0] rd, int drop, logic [4:0] e_addr,
                                logic [15:0] e_wd, int e_stb, int e_done, logic [31:0] e_oe);
        vec_t r;
        r.st = st; r.op = op; r.phy = phy; r.regad = regad; r.data = data; r.rd = rd; r.drop = drop;
        r.e_addr = e_addr; r.e_wd = e_wd; r.e_stb = e_stb; r.e_done = e_done; r.e_rdv = rd; r.e_oe = e_oe;
        return r;
    endfunction
    // A frame is accepted when ST=01, OP is read/write and PHYAD matches; the controller
    // holds OE through bit drop-1 on writes and releases it at TA on reads
    function automatic vec_t model(vec_t v, logic [4:0] a, logic [15:0] w);
        vec_t r;
        bit hdr, rdm, upd;
        r = v;
        hdr = v.st == 2'b01 && (v.op == 2'b01 || v.op == 2'b10) && v.phy == P;
        rdm = v.op == 2'b10;
        upd = hdr && (rdm || v.drop > 13);
        r.e_addr = upd ? v.regad : a;
        r.e_stb = (upd && !rdm && v.drop >= 32) ? 1 : 0;
        r.e_wd = (r.e_stb == 1) ? v.data : w;
        r.e_done = (r.e_stb == 1 || (upd && rdm)) ? 1 : 0;
        r.e_rdv = v.rd;
        r.e_oe = (upd && rdm) ? 32'hFFFF8000 : 32'h0;
        return r;
    endfunction
    task automatic run_vec(input string nm, input vec_t v);
        logic [31:0] b, m;
        logic [15:0] got;
        logic si, so;
        bit rdm;
        b = {v.st, v.op, v.phy, v.regad, 2'b10, v.data};
        rdm = (v.op == 2'b10);
        rd_data = v.rd;
        stb_n = 0; done_n = 0; pair_bad = 0; got = '0; m = '0;
        for (int i = 0; i < 32; i++) begin
            bit_cycle(b[31-i], rdm ? (i < 14) : (i < v.drop), si, so);
            m[i] = so;
            if (i >= 16) got = {got[14:0], si};
        end
        moe = 1'b0;
        repeat (12) @(negedge clk);
        check({nm, "_stb"}, stb_n, v.e_stb);
        check({nm, "_done"}, done_n, v.e_done);
        check({nm, "_pair"}, pair_bad, 0);
        check({nm, "_addr"}, {27'h0, addr}, {27'h0, v.e_addr});
        check({nm, "_wdata"}, {16'h0, wr_data}, {16'h0, v.e_wd});
        check({nm, "_oe_mask"}, m, v.e_oe);
        check({nm, "_oe_end"}, {31'h0, mi_oe}, 32'h0);
        if (rdm && v.e_done == 1) check({nm, "_rdata"}, {16'h0, got}, {16'h0, v.e_rdv});
    endtask
    initial begin
        logic si, so;
        logic [31:0] b;
        tbl[0] = mk(2'b01, 2'b01, P,     5'h0A, 16'hBEEF, 16'h0000, 32, 5'h0A, 16'hBEEF, 1, 1, 32'h0);
        tbl[1] = mk(2'b01, 2'b10, P,     5'h03, 16'h0000, 16'hA5C3, 32, 5'h03, 16'hBEEF, 0, 1, 32'hFFFF8000);
        tbl[2] = mk(2'b01, 2'b01, 5'h07, 5'h0A, 16'h1111, 16'h0000, 32, 5'h03, 16'hBEEF, 0, 0, 32'h0);
        tbl[3] = mk(2'b01, 2'b11, P,     5'h0A, 16'h2222, 16'h0000, 32, 5'h03, 16'hBEEF, 0, 0, 32'h0);
        tbl[4] = mk(2'b01, 2'b01, P,     5'h11, 16'h1234, 16'h0000, 32, 5'h11, 16'h1234, 1, 1, 32'h0);
        tbl[5] = mk(2'b01, 2'b01, P,     5'h02, 16'hFFFF, 16'h0000, 24, 5'h02, 16'h1234, 0, 0, 32'h0);
        tbl[6] = mk(2'b00, 2'b01, P,     5'h1F, 16'h5555, 16'h0000, 32, 5'h02, 16'h1234, 0, 0, 32'h0);
        tbl[7] = mk(2'b01, 2'b10, 5'h07, 5'h05, 16'h0000, 16'hFFFF, 32, 5'h02, 16'h1234, 0, 0, 32'h0);
        repeat (3) @(negedge clk);
        check("rst_addr", {27'h0, addr}, 32'h0);
        check("rst_wdata", {16'h0, wr_data}, 32'h0);
        check("rst_stb", {31'h0, wr_stb}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_in", {31'h0, mi}, 32'h0);
        check("rst_in_oe", {31'h0, mi_oe}, 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 8; k++) run_vec($sformatf("vec%0d", k), tbl[k]);
        // reset while the peripheral is mid-way through returning read data
        rd_data = 16'hC0DE;
        b = {2'b01, 2'b10, P, 5'h06, 2'b10, 16'h0};
        for (int i = 0; i < 21; i++) bit_cycle(b[31-i], i < 14, si, so);
        repeat (4) @(negedge clk);
        check("midrd_oe_before", {31'h0, mi_oe}, 32'h1);
        rst = 1'b1;
        #1;
        check("midrd_oe_reset", {31'h0, mi_oe}, 32'h0);
        check("midrd_addr_reset", {27'h0, addr}, 32'h0);
        check("midrd_wdata_reset", {16'h0, wr_data}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run_vec("post_rst_read", mk(2'b01, 2'b10, P, 5'h04, 16'h0, 16'h0001, 32, 5'h04, 16'h0, 0, 1, 32'hFFFF8000));
        cur_addr = 5'h04;
        cur_wd = 16'h0;
        for (int k = 0; k < 40; k++) begin
            v.st = $urandom_range(0, 1) ? 2'b01 : 2'b00;
            v.op = 2'($urandom_range(0, 3));
            v.phy = $urandom_range(0, 1) ? P : 5'($urandom);
            v.regad = 5'($urandom);
            v.data = 16'($urandom);
            v.rd = 16'($urandom);
            v.drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : 32;
            v = model(v, cur_addr, cur_wd);
            run_vec($sformatf("rnd%0d", k), v);
            cur_addr = v.e_addr;
            cur_wd = v.e_wd;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
